// File: rtl/pe_arb_seq_if.sv
// Handshake bundle between the pending-request arbiter and its environment.
// Carries cnt_clr/coal_cnt only when PE_ARB_COALESCE_CNT_EN is defined.
interface pe_arb_seq_if #(
  parameter int N = 16
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pend;
  logic         busy;
`ifdef PE_ARB_COALESCE_CNT_EN
  logic         cnt_clr;
  logic [15:0]  coal_cnt;
`endif

  modport slave (
    input  req, mode, out_ready,
`ifdef PE_ARB_COALESCE_CNT_EN
    input  cnt_clr,
    output coal_cnt,
`endif
    output out_valid, out_idx, pend, busy
  );

  modport master (
    output req, mode, out_ready,
`ifdef PE_ARB_COALESCE_CNT_EN
    output cnt_clr,
    input  coal_cnt,
`endif
    input  out_valid, out_idx, pend, busy
  );
endinterface

// File: rtl/pe_arb_seq.sv
// Registered request arbiter: sticky pending vector, fixed or round-robin pick, valid/ready output.
// Optional coalesced-request counter enabled by PE_ARB_COALESCE_CNT_EN.
module pe_arb_seq #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_arb_seq_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         busy_q, busy_d;
  logic [W-1:0] outIdx_q, outIdx_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         hs;
  logic [N-1:0] clrVec;
  logic [N-1:0] effVec;
  logic [W-1:0] searchBase;
  logic [W-1:0] candIdx;
  logic [W-1:0] sel;

  assign hs = (state_q == ST_PRESENT) && bus.out_ready;

  always_comb begin
    clrVec = '0;
    for (int i = 0; i < N; i++) begin
      if (hs && (outIdx_q == W'(i))) clrVec[i] = 1'b1;
    end
    effVec = (pend_q & ~clrVec) | bus.req;
  end

  // On a handshake the accepted index becomes the pointer this same edge, so search from it directly.
  always_comb begin
    searchBase = '0;
    candIdx    = '0;
    sel        = '0;
    if (bus.mode) searchBase = hs ? outIdx_q : ptr_q;
    for (int k = N; k >= 1; k--) begin
      candIdx = W'((int'(searchBase) + N - k) % N);
      if (effVec[candIdx]) sel = candIdx;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = effVec;
    busy_d   = (effVec != '0);
    outIdx_d = outIdx_q;
    ptr_d    = ptr_q;
    if (hs) ptr_d = outIdx_q;
    case (state_q)
      ST_IDLE: begin
        if (effVec != '0) begin
          state_d  = ST_PRESENT;
          outIdx_d = sel;
        end
      end
      ST_PRESENT: begin
        if (hs) begin
          if (effVec != '0) begin
            outIdx_d = sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      busy_q   <= 1'b0;
      outIdx_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      outIdx_q <= outIdx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == ST_PRESENT);
  assign bus.out_idx   = outIdx_q;
  assign bus.pend      = pend_q;
  assign bus.busy      = busy_q;

`ifdef PE_ARB_COALESCE_CNT_EN
  logic [15:0]  coal_q, coal_d;
  logic [N-1:0] hitVec;
  logic [15:0]  coalInc;
  logic [16:0]  coalSum;

  // A request landing on a bit that stays pending this cycle is merged; count those merges.
  always_comb begin
    hitVec  = bus.req & pend_q & ~clrVec;
    coalInc = '0;
    for (int i = 0; i < N; i++) begin
      coalInc = coalInc + 16'(hitVec[i]);
    end
    coalSum = {1'b0, coal_q} + {1'b0, coalInc};
    if (bus.cnt_clr) begin
      coal_d = '0;
    end else if (coalSum[16]) begin
      coal_d = 16'hFFFF;
    end else begin
      coal_d = coalSum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coal_q <= '0;
    end else begin
      coal_q <= coal_d;
    end
  end

  assign bus.coal_cnt = coal_q;
`endif

endmodule

// File: tb/tb_pe_arb_seq.sv
// Directed self-checking bench for pe_arb_seq (N=16), hand-computed expectations.
// Coalescing-counter checks run only when PE_ARB_COALESCE_CNT_EN is defined.
module tb_pe_arb_seq;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  pe_arb_seq_if #(.N(16)) bus ();

  pe_arb_seq #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs just after an edge, then advance to 1ns past the next edge.
  task automatic applyStimulus(input logic [15:0] r, input logic m, input logic rdy);
    bus.req       = r;
    bus.mode      = m;
    bus.out_ready = rdy;
    tick();
  endtask

  task automatic doReset();
    bus.req       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
`ifdef PE_ARB_COALESCE_CNT_EN
    bus.cnt_clr   = 1'b0;
`endif
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b1;
    doReset();

    // Reset held with all requests asserted, then released
    rst_n   = 1'b0;
    bus.req = 16'hFFFF;
    tick();
    tick();
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_pend",  32'(bus.pend),      32'h0);
    checkOutput("rst_busy",  32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    checkOutput("rel_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("rel_idx",   32'(bus.out_idx),   32'd15);
    checkOutput("rel_pend",  32'(bus.pend),      32'hFFFF);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pend",  32'(bus.pend),      32'h0);
    checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
    doReset();

    // Single request, fixed mode
    applyStimulus(16'h0100, 1'b0, 1'b1);
    checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_idx",   32'(bus.out_idx),   32'd8);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("single_drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("single_drain_pend",  32'(bus.pend),      32'h0);
    checkOutput("single_drain_busy",  32'(bus.busy),      32'd0);
    doReset();

    // One-cycle burst, grants in descending order back to back
    applyStimulus(16'h8421, 1'b0, 1'b1);
    checkOutput("burst_g0", 32'(bus.out_idx), 32'd15);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("burst_g1", 32'(bus.out_idx), 32'd10);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("burst_g2", 32'(bus.out_idx), 32'd5);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("burst_g3", 32'(bus.out_idx), 32'd0);
    checkOutput("burst_g3_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("burst_end_valid", 32'(bus.out_valid), 32'd0);
    doReset();

    // Backpressure holds the presented index even against a higher request
    applyStimulus(16'h0004, 1'b0, 1'b0);
    checkOutput("bp_idx0",   32'(bus.out_idx),   32'd2);
    checkOutput("bp_valid0", 32'(bus.out_valid), 32'd1);
    applyStimulus(16'h8000, 1'b0, 1'b0);
    checkOutput("bp_hold_idx", 32'(bus.out_idx), 32'd2);
    checkOutput("bp_pend",     32'(bus.pend),    32'h8004);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("bp_next_idx",  32'(bus.out_idx), 32'd15);
    checkOutput("bp_next_pend", 32'(bus.pend),    32'h8000);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("bp_end_valid", 32'(bus.out_valid), 32'd0);
    doReset();

    // Round-robin with a held request vector rotates through all sources
    applyStimulus(16'h0111, 1'b1, 1'b1);
    checkOutput("rr_g0", 32'(bus.out_idx), 32'd8);
    applyStimulus(16'h0111, 1'b1, 1'b1);
    checkOutput("rr_g1", 32'(bus.out_idx), 32'd4);
    applyStimulus(16'h0111, 1'b1, 1'b1);
    checkOutput("rr_g2", 32'(bus.out_idx), 32'd0);
    applyStimulus(16'h0111, 1'b1, 1'b1);
    checkOutput("rr_g3", 32'(bus.out_idx), 32'd8);
    applyStimulus(16'h0111, 1'b1, 1'b1);
    checkOutput("rr_g4", 32'(bus.out_idx), 32'd4);
    doReset();

    // Same stimulus in fixed mode keeps granting the top index
    applyStimulus(16'h0111, 1'b0, 1'b1);
    checkOutput("fx_g0", 32'(bus.out_idx), 32'd8);
    applyStimulus(16'h0111, 1'b0, 1'b1);
    checkOutput("fx_g1", 32'(bus.out_idx), 32'd8);
    applyStimulus(16'h0111, 1'b0, 1'b1);
    checkOutput("fx_g2", 32'(bus.out_idx), 32'd8);
    doReset();

    // Request on the index being accepted re-arms it
    applyStimulus(16'h0008, 1'b0, 1'b0);
    checkOutput("sd_idx0", 32'(bus.out_idx), 32'd3);
    applyStimulus(16'h0008, 1'b0, 1'b1);
    checkOutput("sd_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sd_idx1",  32'(bus.out_idx),   32'd3);
    checkOutput("sd_pend",  32'(bus.pend),      32'h0008);
`ifdef PE_ARB_COALESCE_CNT_EN
    checkOutput("coal_zero", 32'(bus.coal_cnt), 32'd0);
`endif
    applyStimulus(16'h0008, 1'b0, 1'b0);
    checkOutput("sd_hold_idx", 32'(bus.out_idx), 32'd3);
`ifdef PE_ARB_COALESCE_CNT_EN
    checkOutput("coal_one", 32'(bus.coal_cnt), 32'd1);
    bus.cnt_clr = 1'b1;
    applyStimulus(16'h0008, 1'b0, 1'b0);
    bus.cnt_clr = 1'b0;
    checkOutput("coal_clr", 32'(bus.coal_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
